// File: rtl/and5_rr_sched.sv
// ============================================================================
//  Module      : and5_rr_sched
//  Description : Round-robin scheduler sharing one registered 5-input AND
//                evaluation path among NREQ requesters. Two registered stages
//                (capture, output) with a ready/valid handshake toward a
//                single consumer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module and5_rr_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                CK,
    input  logic                CD,
    input  logic [NREQ-1:0]     REQ,
    input  logic [5*NREQ-1:0]   OPA,
    output logic [NREQ-1:0]     GNT,
    input  logic                RDY,
    output logic                ZV,
    output logic                Z,
    output logic [IDW-1:0]      ZID
);

    localparam logic [IDW:0]    NREQ_W  = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0]  LAST_ID = IDW'(NREQ - 1);

    // capture stage and arbitration pointer
    logic                s1_v;
    logic [4:0]          s1_op;
    logic [IDW-1:0]      s1_id;
    logic [IDW-1:0]      ptr;

    // combinational arbitration results
    logic [NREQ-1:0]     elig;
    logic                found;
    logic [IDW-1:0]      win;
    logic [IDW:0]        cand;
    logic [IDW-1:0]      ptr_next;
    logic [4:0]          win_op;
    logic [NREQ-1:0]     win_oh;
    logic                adv2;
    logic                load1;

    // Rotating-priority search: first eligible index starting at ptr.
    // A requester granted last cycle is masked so it has a cycle to drop REQ.
    always_comb begin
        elig  = REQ & ~GNT;
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!found && elig[cand[IDW-1:0]]) begin
                found = 1'b1;
                win   = cand[IDW-1:0];
            end
        end
    end

    // Handshake terms, winner operand slice, one-hot grant and next pointer.
    always_comb begin
        adv2     = s1_v & (~ZV | RDY);
        load1    = found & (~s1_v | adv2);
        win_op   = OPA[5*win +: 5];
        win_oh   = NREQ'(1) << win;
        ptr_next = (win == LAST_ID) ? '0 : win + IDW'(1);
    end

    // Capture stage: load the winner's operand, issue its grant pulse, rotate.
    always_ff @(posedge CK) begin
        if (CD) begin
            s1_v  <= 1'b0;
            s1_op <= '0;
            s1_id <= '0;
            GNT   <= '0;
            ptr   <= '0;
        end else if (load1) begin
            s1_v  <= 1'b1;
            s1_op <= win_op;
            s1_id <= win;
            GNT   <= win_oh;
            ptr   <= ptr_next;
        end else begin
            GNT   <= '0;
            s1_v  <= s1_v & ~adv2;
        end
    end

    // Output stage: evaluate the AND when advancing, clear valid on consumption.
    always_ff @(posedge CK) begin
        if (CD) begin
            ZV  <= 1'b0;
            Z   <= 1'b0;
            ZID <= '0;
        end else if (adv2) begin
            ZV  <= 1'b1;
            Z   <= &s1_op;
            ZID <= s1_id;
        end else if (ZV && RDY) begin
            ZV  <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_and5_rr_sched.sv
// ============================================================================
//  Module      : tb_and5_rr_sched
//  Description : Self-checking bench for and5_rr_sched: directed scenarios
//                plus randomized traffic against a queue-based model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_and5_rr_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic               CK;
    logic               CD;
    logic [NREQ-1:0]    REQ;
    logic [5*NREQ-1:0]  OPA;
    logic [NREQ-1:0]    GNT;
    logic               RDY;
    logic               ZV;
    logic               Z;
    logic [IDW-1:0]     ZID;

    int n_cmp = 0;
    int n_bad = 0;

    and5_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .CK  (CK),
        .CD  (CD),
        .REQ (REQ),
        .OPA (OPA),
        .GNT (GNT),
        .RDY (RDY),
        .ZV  (ZV),
        .Z   (Z),
        .ZID (ZID)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // ------------------------------------------------------------------
    // Reference model: a 2-deep result queue. An entry becomes visible to
    // the consumer one edge after it is accepted; the visible head leaves
    // when RDY is high; a new request is accepted when fewer than two
    // entries remain after that.
    // ------------------------------------------------------------------
    typedef struct {
        int id;
        bit z;
        int age;
    } ent_t;

    ent_t            q[$];
    logic [NREQ-1:0] m_gnt;
    int              m_ptr;
    bit              m_z;
    int              m_zid;
    logic [NREQ-1:0] m_elig;
    int              m_win;
    logic [4:0]      m_sl;

    always @(posedge CK) begin
        if (CD) begin
            q.delete();
            m_gnt = '0;
            m_ptr = 0;
            m_z   = 1'b0;
            m_zid = 0;
        end else begin
            m_elig = REQ & ~m_gnt;
            if (q.size() > 0 && q[0].age >= 1 && RDY) begin
                void'(q.pop_front());
            end
            m_win = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (m_win < 0 && m_elig[(m_ptr + k) % NREQ]) begin
                    m_win = (m_ptr + k) % NREQ;
                end
            end
            foreach (q[i]) q[i].age++;
            m_gnt = '0;
            if (m_win >= 0 && q.size() < 2) begin
                m_sl = OPA[5*m_win +: 5];
                q.push_back('{id: m_win, z: (&m_sl), age: 0});
                m_gnt[m_win] = 1'b1;
                m_ptr = (m_win + 1) % NREQ;
            end
            if (q.size() > 0 && q[0].age >= 1) begin
                m_z   = q[0].z;
                m_zid = q[0].id;
            end
        end
    end

    task automatic apply_reset();
        @(negedge CK);
        CD  = 1'b1;
        REQ = '0;
        @(negedge CK);
        CD  = 1'b0;
    endtask

    task automatic rand_opa();
        for (int i = 0; i < NREQ; i++) begin
            OPA[5*i +: 5] = ($urandom % 3 == 0) ? 5'h1F : 5'($urandom);
        end
    endtask

    task automatic test_reset();
        CD  = 1'b1;
        REQ = 4'b1111;
        RDY = 1'b1;
        rand_opa();
        for (int c = 0; c < 2; c++) begin
            @(negedge CK);
            n_cmp++; if (GNT !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", GNT); end
            n_cmp++; if (ZV !== 1'b0) begin n_bad++; $display("FAIL reset_zv: got %b want 0", ZV); end
            n_cmp++; if (Z !== 1'b0) begin n_bad++; $display("FAIL reset_z: got %b want 0", Z); end
            n_cmp++; if (ZID !== 2'd0) begin n_bad++; $display("FAIL reset_zid: got %0d want 0", ZID); end
        end
        CD = 1'b0;
        @(negedge CK);
        n_cmp++; if (GNT !== 4'b0001) begin n_bad++; $display("FAIL reset_first_gnt: got %b want 0001", GNT); end
        REQ = '0;
        repeat (3) @(negedge CK);
    endtask

    task automatic test_single();
        logic [4:0] pat [2];
        pat[0] = 5'b11111;
        pat[1] = 5'b11011;
        apply_reset();
        RDY = 1'b1;
        for (int p = 0; p < 2; p++) begin
            REQ = 4'b0100;
            rand_opa();
            OPA[14:10] = pat[p];
            @(negedge CK);
            n_cmp++; if (GNT !== 4'b0100) begin n_bad++; $display("FAIL single_gnt: got %b want 0100", GNT); end
            REQ = '0;
            OPA = '0;
            @(negedge CK);
            n_cmp++; if (GNT !== 4'b0000) begin n_bad++; $display("FAIL single_gnt_drop: got %b want 0000", GNT); end
            n_cmp++; if (ZV !== 1'b1) begin n_bad++; $display("FAIL single_zv: got %b want 1", ZV); end
            n_cmp++; if (Z !== (p == 0)) begin n_bad++; $display("FAIL single_z: got %b want %b", Z, (p == 0)); end
            n_cmp++; if (ZID !== 2'd2) begin n_bad++; $display("FAIL single_zid: got %0d want 2", ZID); end
            @(negedge CK);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        RDY = 1'b1;
        REQ = 4'b1111;
        OPA = '1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CK);
            n_cmp++; if (GNT !== 4'(1 << (i % 4))) begin n_bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, GNT, 4'(1 << (i % 4))); end
            if (i >= 1) begin
                n_cmp++; if (ZV !== 1'b1 || Z !== 1'b1 || ZID !== 2'((i - 1) % 4)) begin
                    n_bad++; $display("FAIL rr_out[%0d]: got zv=%b z=%b zid=%0d want zv=1 z=1 zid=%0d", i, ZV, Z, ZID, (i - 1) % 4);
                end
            end
        end
        REQ = '0;
        repeat (3) @(negedge CK);
    endtask

    task automatic test_backpressure();
        apply_reset();
        RDY = 1'b0;
        REQ = 4'b0011;
        rand_opa();
        @(negedge CK);
        n_cmp++; if (GNT !== 4'b0001 || ZV !== 1'b0) begin n_bad++; $display("FAIL bp_first: got gnt=%b zv=%b want gnt=0001 zv=0", GNT, ZV); end
        @(negedge CK);
        n_cmp++; if (GNT !== 4'b0010 || ZV !== 1'b1 || ZID !== 2'd0) begin n_bad++; $display("FAIL bp_second: got gnt=%b zv=%b zid=%0d want gnt=0010 zv=1 zid=0", GNT, ZV, ZID); end
        for (int c = 0; c < 5; c++) begin
            @(negedge CK);
            n_cmp++; if (GNT !== 4'b0000 || ZV !== 1'b1 || ZID !== 2'd0) begin
                n_bad++; $display("FAIL bp_hold[%0d]: got gnt=%b zv=%b zid=%0d want gnt=0000 zv=1 zid=0", c, GNT, ZV, ZID);
            end
        end
        RDY = 1'b1;
        @(negedge CK);
        n_cmp++; if (GNT !== 4'b0001 || ZV !== 1'b1 || ZID !== 2'd1) begin n_bad++; $display("FAIL bp_release: got gnt=%b zv=%b zid=%0d want gnt=0001 zv=1 zid=1", GNT, ZV, ZID); end
        REQ = '0;
        @(negedge CK);
        n_cmp++; if (GNT !== 4'b0000 || ZV !== 1'b1 || ZID !== 2'd0) begin n_bad++; $display("FAIL bp_next: got gnt=%b zv=%b zid=%0d want gnt=0000 zv=1 zid=0", GNT, ZV, ZID); end
        @(negedge CK);
        n_cmp++; if (ZV !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got zv=%b want 0", ZV); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        RDY = 1'b1;
        REQ = 4'b1000;
        OPA = '1;
        @(negedge CK);
        n_cmp++; if (GNT !== 4'b1000) begin n_bad++; $display("FAIL mid_gnt3: got %b want 1000", GNT); end
        CD  = 1'b1;
        REQ = '0;
        @(negedge CK);
        CD  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_cmp++; if (ZV !== 1'b0 || GNT !== 4'b0000) begin n_bad++; $display("FAIL mid_no_zv[%0d]: got zv=%b gnt=%b want zv=0 gnt=0000", c, ZV, GNT); end
            @(negedge CK);
        end
        REQ = 4'b1010;
        @(negedge CK);
        n_cmp++; if (GNT !== 4'b0010) begin n_bad++; $display("FAIL mid_after_gnt: got %b want 0010", GNT); end
        REQ = '0;
        repeat (4) @(negedge CK);
    endtask

    task automatic test_hog();
        logic prev0;
        int   g0;
        apply_reset();
        RDY = 1'b1;
        REQ = 4'b0001;
        rand_opa();
        @(negedge CK);
        n_cmp++; if (GNT !== 4'b0001) begin n_bad++; $display("FAIL hog_first: got %b want 0001", GNT); end
        REQ = 4'b0011;
        @(negedge CK);
        n_cmp++; if (GNT !== 4'b0010) begin n_bad++; $display("FAIL hog_other: got %b want 0010", GNT); end
        REQ   = 4'b0001;
        prev0 = 1'b0;
        g0    = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CK);
            n_cmp++; if (GNT[0] && prev0) begin n_bad++; $display("FAIL hog_spacing[%0d]: got back-to-back gnt0 want gap", c); end
            prev0 = GNT[0];
            if (GNT[0]) g0++;
        end
        n_cmp++; if (g0 !== 4) begin n_bad++; $display("FAIL hog_count: got %0d grants want 4", g0); end
        REQ = '0;
        repeat (3) @(negedge CK);
    endtask

    task automatic test_random();
        bit exp_zv;
        for (int c = 0; c < 400; c++) begin
            @(negedge CK);
            exp_zv = (q.size() > 0 && q[0].age >= 1);
            n_cmp++; if (GNT !== m_gnt) begin n_bad++; $display("FAIL rand_gnt[%0d]: got %b want %b", c, GNT, m_gnt); end
            n_cmp++; if (ZV !== exp_zv) begin n_bad++; $display("FAIL rand_zv[%0d]: got %b want %b", c, ZV, exp_zv); end
            n_cmp++; if (Z !== m_z || ZID !== 2'(m_zid)) begin n_bad++; $display("FAIL rand_out[%0d]: got z=%b zid=%0d want z=%b zid=%0d", c, Z, ZID, m_z, m_zid); end
            CD  = ($urandom % 50 == 0);
            REQ = 4'($urandom);
            RDY = ($urandom % 4 != 0);
            rand_opa();
        end
        CD  = 1'b0;
        REQ = '0;
        repeat (3) @(negedge CK);
    endtask

    initial begin
        CD  = 1'b1;
        REQ = '0;
        OPA = '0;
        RDY = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_hog();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
